// File: rtl/lift_pkg.sv
// Shared types and helpers for the SCAN lift controller.
package lift_pkg;

    typedef struct packed {
        logic up;
        logic down;
    } direction_t;

    typedef enum logic [2:0] {
        IDLE,
        MOVE,
        OPENING,
        HOLD,
        CLOSING,
        ESTOP,
        FAULT
    } lift_state_t;

    localparam direction_t DIR_UP   = '{up: 1'b1, down: 1'b0};
    localparam direction_t DIR_DOWN = '{up: 1'b0, down: 1'b1};

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/lift_req_scan.sv
// Combinational request scan: pending calls above, below and at the car position.
module lift_req_scan
    import lift_pkg::*;
#(
    parameter int unsigned FLOOR_NUM = 16
) (
    input  direction_t [FLOOR_NUM-1:0] floors_direction_led,
    input  logic       [FLOOR_NUM-1:0] floors_select_led,
    input  logic       [FLOOR_NUM-1:0] lift_detector,
    output logic                       above,
    output logic                       below,
    output logic                       here_cab,
    output direction_t                 here_hall
);

    logic seen;
    logic pending;
    logic call;

    // Single low-to-high sweep: calls before the position are below, after it above.
    always_comb begin
        above     = 1'b0;
        below     = 1'b0;
        here_cab  = 1'b0;
        here_hall = '0;
        seen      = 1'b0;
        pending   = 1'b0;
        call      = 1'b0;
        for (int unsigned i = 0; i < FLOOR_NUM; i++) begin
            call = floors_select_led[i] | floors_direction_led[i].up | floors_direction_led[i].down;
            if (lift_detector[i]) begin
                below     = pending;
                seen      = 1'b1;
                here_cab  = floors_select_led[i];
                here_hall = floors_direction_led[i];
            end else if (seen) begin
                above = above | call;
            end else begin
                pending = pending | call;
            end
        end
    end

endmodule

// File: rtl/lift_scan_ctrl.sv
// Single-car SCAN lift controller with door sequencing, emergency stop and sticky fault.
module lift_scan_ctrl
    import lift_pkg::*;
#(
    parameter int unsigned FLOOR_NUM    = 16,
    parameter int unsigned DOOR_HOLD    = 10,
    parameter int unsigned DOOR_TIMEOUT = 256
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  direction_t [FLOOR_NUM-1:0]      floors_direction,
    input  logic       [FLOOR_NUM-1:0]      floors_select,
    input  logic       [FLOOR_NUM-1:0]      lift_detector,
    input  logic       [FLOOR_NUM-1:0]      lift_stop_detector,
    input  logic                            door_open_fb,
    input  logic                            door_closed_fb,
    input  logic                            door_obstruct,
    input  logic                            emergency_stop,
    output direction_t                      lift_engine,
    output logic                            door_cmd,
    output direction_t [FLOOR_NUM-1:0]      floors_direction_led,
    output logic       [FLOOR_NUM-1:0]      floors_select_led,
    output logic       [$clog2(FLOOR_NUM)-1:0] current_floor,
    output direction_t                      travel_dir,
    output logic                            fault
);

    localparam int unsigned FW = $clog2(FLOOR_NUM);
    localparam int unsigned CW = $clog2(max_u(DOOR_HOLD, DOOR_TIMEOUT) + 1);

    lift_state_t state, state_nx;
    logic [CW-1:0] cnt, cnt_nx;
    direction_t td, td_nx, pref, pref_nx, served, served_nx, raw_engine;
    direction_t [FLOOR_NUM-1:0] hall_led, hall_nx;
    logic [FLOOR_NUM-1:0] sel_led, sel_nx, pos;
    logic [FW-1:0] cur_floor, det_floor;
    logic door_last, serve, hold_press;
    logic above, below, here_cab, ahead, behind, at_stop, terminal, stop_now;
    direction_t here_hall;

    // Car position: detector zone, falling back to the last seen floor between zones.
    always_comb begin
        pos       = lift_detector;
        det_floor = '0;
        for (int unsigned i = 0; i < FLOOR_NUM; i++) begin
            if (lift_detector[i]) det_floor = FW'(i);
        end
        if (lift_detector == '0) begin
            pos            = '0;
            pos[cur_floor] = 1'b1;
        end
    end

    lift_req_scan #(.FLOOR_NUM(FLOOR_NUM)) u_scan (
        .floors_direction_led(hall_led),
        .floors_select_led   (sel_led),
        .lift_detector       (pos),
        .above               (above),
        .below               (below),
        .here_cab            (here_cab),
        .here_hall           (here_hall)
    );

    assign ahead     = (td.up & above) | (td.down & below);
    assign behind    = (td.up & below) | (td.down & above);
    assign at_stop   = |lift_stop_detector;
    assign terminal  = lift_stop_detector[0] | lift_stop_detector[FLOOR_NUM-1];
    assign stop_now  = at_stop & (here_cab | (td.up & here_hall.up) | (td.down & here_hall.down)
                       | (!ahead & (here_hall.up | here_hall.down)) | terminal);
    assign served_nx = '{up: td.up | !ahead, down: td.down | !ahead};

    // Same-floor press in a direction already served restarts the hold.
    always_comb begin
        hold_press = 1'b0;
        for (int unsigned i = 0; i < FLOOR_NUM; i++) begin
            if (pos[i]) begin
                hold_press = floors_select[i] | (served.up & floors_direction[i].up)
                             | (served.down & floors_direction[i].down);
            end
        end
    end

    // Next state, door counter and scan direction.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        td_nx    = td;
        pref_nx  = pref;
        serve    = 1'b0;
        case (state)
            IDLE: begin
                td_nx = '0;
                if ((here_cab | here_hall.up | here_hall.down) && at_stop) begin
                    state_nx = OPENING;
                    cnt_nx   = '0;
                end else if (above && below) begin
                    state_nx = MOVE;
                    td_nx    = pref;
                end else if (above) begin
                    state_nx = MOVE;
                    td_nx    = DIR_UP;
                    pref_nx  = DIR_UP;
                end else if (below) begin
                    state_nx = MOVE;
                    td_nx    = DIR_DOWN;
                    pref_nx  = DIR_DOWN;
                end
            end
            MOVE: begin
                if (stop_now) begin
                    state_nx = OPENING;
                    cnt_nx   = '0;
                end
            end
            OPENING: begin
                if (door_open_fb) begin
                    state_nx = HOLD;
                    cnt_nx   = '0;
                    serve    = 1'b1;
                end else if (cnt == CW'(DOOR_TIMEOUT - 1)) begin
                    state_nx = FAULT;
                end else begin
                    cnt_nx = cnt + CW'(1);
                end
            end
            HOLD: begin
                if (door_obstruct || hold_press) begin
                    cnt_nx = '0;
                end else if (cnt == CW'(DOOR_HOLD - 1)) begin
                    state_nx = CLOSING;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = cnt + CW'(1);
                end
            end
            CLOSING: begin
                if (door_obstruct) begin
                    state_nx = OPENING;
                    cnt_nx   = '0;
                end else if (door_closed_fb) begin
                    if (ahead) begin
                        state_nx = MOVE;
                    end else if (behind) begin
                        state_nx = MOVE;
                        td_nx    = '{up: td.down, down: td.up};
                        pref_nx  = '{up: td.down, down: td.up};
                    end else begin
                        state_nx = IDLE;
                        td_nx    = '0;
                    end
                end else if (cnt == CW'(DOOR_TIMEOUT - 1)) begin
                    state_nx = FAULT;
                end else begin
                    cnt_nx = cnt + CW'(1);
                end
            end
            ESTOP: begin
                if (!emergency_stop) begin
                    state_nx = IDLE;
                    td_nx    = '0;
                end
            end
            FAULT: state_nx = FAULT;
            default: state_nx = IDLE;
        endcase
        if (emergency_stop && state != FAULT) begin
            state_nx = ESTOP;
            td_nx    = td;
            pref_nx  = pref;
            serve    = 1'b0;
        end
    end

    // Call LEDs: latch presses; a serve clears and beats a simultaneous press.
    always_comb begin
        sel_nx  = sel_led;
        hall_nx = hall_led;
        for (int unsigned i = 0; i < FLOOR_NUM; i++) begin
            sel_nx[i]       = sel_led[i] | floors_select[i];
            hall_nx[i].up   = hall_led[i].up | floors_direction[i].up;
            hall_nx[i].down = hall_led[i].down | floors_direction[i].down;
            if (pos[i] && state == HOLD) begin
                sel_nx[i] = sel_led[i];
                if (served.up)   hall_nx[i].up   = hall_led[i].up;
                if (served.down) hall_nx[i].down = hall_led[i].down;
            end
            if (pos[i] && serve) begin
                sel_nx[i] = 1'b0;
                if (served_nx.up)   hall_nx[i].up   = 1'b0;
                if (served_nx.down) hall_nx[i].down = 1'b0;
            end
        end
    end

    // Outputs: engine gated combinationally by every safety interlock.
    always_comb begin
        raw_engine       = (state == MOVE && !stop_now) ? td : '0;
        lift_engine.up   = raw_engine.up & !emergency_stop & door_closed_fb
                           & !lift_stop_detector[FLOOR_NUM-1];
        lift_engine.down = raw_engine.down & !emergency_stop & door_closed_fb
                           & !lift_stop_detector[0];
        case (state)
            OPENING, HOLD: door_cmd = 1'b1;
            ESTOP:         door_cmd = door_last;
            default:       door_cmd = 1'b0;
        endcase
    end

    assign fault                = (state == FAULT);
    assign travel_dir           = td;
    assign floors_direction_led = hall_led;
    assign floors_select_led    = sel_led;
    assign current_floor        = cur_floor;

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            td        <= '0;
            pref      <= DIR_UP;
            served    <= '0;
            door_last <= 1'b0;
            cur_floor <= '0;
            sel_led   <= '0;
            hall_led  <= '0;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            td        <= td_nx;
            pref      <= pref_nx;
            door_last <= door_cmd;
            sel_led   <= sel_nx;
            hall_led  <= hall_nx;
            if (serve) served <= served_nx;
            if (lift_detector != '0) cur_floor <= det_floor;
        end
    end

endmodule

// File: doc/lift_scan_ctrl.md
# lift_scan_ctrl

Next-generation single-car lift controller. It generalises the existing controller with:
- direction-preserving SCAN scheduling that reverses without passing through IDLE,
- door open/hold/close sequencing with obstruction and timeouts,
- emergency stop, a sticky fault and an encoded floor indicator.

It sits between the floor/cabin buttons and sensors and the engine and door actuators, in the same place as the current controller.

## Interface
Parameters:
- FLOOR_NUM, 16, number of floors (≥2)
- DOOR_HOLD, 10, cycles the door stays open once fully open
- DOOR_TIMEOUT, 256, max cycles allowed for a door open or close movement

Ports:
- clk  in  1  single clock
- rst_n  in  1  reset, synchronous and active-low
- floors_direction  in  lift_pkg::direction_t [FLOOR_NUM]  hall call buttons; pulse or level
- floors_select  in  [FLOOR_NUM]  cabin buttons
- lift_detector  in  [FLOOR_NUM]  floor zone; one-hot or zero
- lift_stop_detector  in  [FLOOR_NUM]  exact stop position; one-hot or zero
- door_open_fb  in  1  door fully open limit switch
- door_closed_fb  in  1  door fully closed limit switch
- door_obstruct  in  1  door light curtain
- emergency_stop  in  1  level
- lift_engine  out  lift_pkg::direction_t  engine up/down; never both set
- door_cmd  out  1  1 = drive door open, 0 = drive door closed
- floors_direction_led  out  lift_pkg::direction_t [FLOOR_NUM]  latched hall calls
- floors_select_led  out  [FLOOR_NUM]  latched cabin calls
- current_floor  out  $clog2(FLOOR_NUM)  last floor seen on lift_detector
- travel_dir  out  lift_pkg::direction_t  committed scan direction; zero when IDLE
- fault  out  1  sticky door timeout flag

## Operation
All inputs are already synchronous to clk. Every output resets to 0; the internal scan preference resets to up.

Call latching:
- A button press sets its LED on the next edge.
- A floor is "served" on the cycle of entry to HOLD:
  - cabin LED and the hall LED matching travel_dir are cleared;
  - if no calls remain beyond the floor in travel_dir, both hall LEDs are cleared.
- Presses at the served floor, in a served direction, are not latched while in HOLD; they restart the hold counter instead.

Request scan (combinational): above / below / here flags, computed against the floor encoded from lift_detector.

State machine:
- IDLE:
  - call at a floor whose lift_stop_detector is set → OPENING;
  - else if calls exist on both sides → MOVE toward the side given by the scan preference;
  - else → MOVE toward the single side that has calls.
- MOVE:
  - engine drives travel_dir;
  - on lift_stop_detector[i], stop if: floor i has a cabin call, or a hall call in travel_dir, or no calls lie beyond i (any hall call at i), or i is a terminal floor;
  - stopping → OPENING.
- OPENING: door_cmd=1. door_open_fb → HOLD; timeout → FAULT.
- HOLD: door_cmd=1, counts DOOR_HOLD cycles. Obstruction or a same-floor press reloads the count. Expiry → CLOSING.
- CLOSING: door_cmd=0.
  - obstruction → OPENING;
  - door_closed_fb → MOVE in travel_dir if calls lie ahead; else MOVE reversed if calls lie behind; else IDLE;
  - timeout → FAULT.
- ESTOP, entered from any state except FAULT while emergency_stop is high: engine off, door_cmd held. Release → IDLE.
- FAULT: engine off, door_cmd=0, fault=1. Left only by reset.

Engine safety:
- lift_engine is gated combinationally by !emergency_stop, by FAULT, and by door_closed_fb.
- Up is also gated by !lift_stop_detector[FLOOR_NUM-1]; down by !lift_stop_detector[0].

## Timing
- Button press → LED high: 1 cycle.
- lift_stop_detector with a stop condition → lift_engine low: same cycle (combinational gate). The state enters OPENING on the next edge.
- door_open_fb → HOLD: 1 cycle. HOLD lasts exactly DOOR_HOLD cycles without reload.
- The timeout counter starts at OPENING/CLOSING entry. FAULT is entered on the edge after DOOR_TIMEOUT cycles without feedback.
- emergency_stop → lift_engine zero: same cycle. ESTOP state is registered 1 cycle later.
- Reset mid-motion: engine is zero on the first edge with rst_n low, and all LEDs are cleared.
- current_floor updates 1 cycle after lift_detector; it holds its value while lift_detector is zero.
- A simultaneous press and serve at the same floor: serve wins.

## Structure
- lift_pkg gains lift_state_t (IDLE, MOVE, OPENING, HOLD, CLOSING, ESTOP, FAULT). direction_t stays in lift_pkg unchanged.
- Sub-module lift_req_scan: purely combinational. Takes the LEDs and lift_detector; produces above, below and here flags split per direction.
- Door and hold counters are sized $clog2(max(DOOR_HOLD, DOOR_TIMEOUT)+1).

## Test plan
All scenarios use FLOOR_NUM=8, DOOR_HOLD=4, DOOR_TIMEOUT=16.
- Car at floor 0, cabin press floor 5 → engine up. At stop_detector[5] the engine drops in the same cycle, door_cmd=1, floors_select_led[5] clears on HOLD entry.
- Car at floor 2 going up with calls at 6 (cabin) and 1 (hall up) → serves 6 first, then MOVE down with no IDLE cycle between, and stops at 1.
- HOLD at floor 3, door_obstruct pulsed at hold cycle 3 → door closes 4 cycles after the pulse. Obstruction during CLOSING → back to OPENING.
- door_open_fb never asserted → fault=1 after 16 cycles and stays 1 until rst_n=0.
- emergency_stop raised mid-MOVE → lift_engine=0 the same cycle. After release: IDLE, then resume toward the remaining call.
- Hall up and hall down both pressed at top floor 7 with the car arriving upward → both LEDs clear and the car goes to IDLE.
